// File: rtl/alu_limb_seq.sv
// Multi-cycle adder/subtractor: one LIMB-bit slice per clock, LSB first, carry chained
// between slices. Result and Z/N/C/V flags are registered once on completion.
module alu_limb_seq #(
  parameter int WIDTH = 32,
  parameter int LIMB  = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             alu_start_in,
  input  logic [1:0]       alu_op_in,
  input  logic             alu_carry_in,
  input  logic [WIDTH-1:0] alu_A_in,
  input  logic [WIDTH-1:0] alu_B_in,
  output logic             alu_busy_out,
  output logic             alu_done_out,
  output logic [WIDTH-1:0] alu_out,
  output logic             alu_Z_out,
  output logic             alu_N_out,
  output logic             alu_C_out,
  output logic             alu_V_out,
  output logic [1:0]       dbg_state
);

  localparam int NLIMB = WIDTH / LIMB;
  localparam int CW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Handshake: alu_start_in is sampled only in IDLE; alu_busy_out is high for the
  // NLIMB RUN cycles; alu_done_out pulses for one cycle when result/flags are valid.
  state_t state, state_next;

  logic [WIDTH-1:0] a_q, b_q, work_q, work_next;
  logic             carry_q;
  logic [CW-1:0]    count;
  logic             load, step, last;

  logic [LIMB-1:0]  a_sl, b_sl;
  logic [LIMB:0]    sum;
  logic             v_slice;
  int               idx;

  assign dbg_state = state;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= S_IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next   = state;
    alu_busy_out = 1'b0;
    alu_done_out = 1'b0;
    load         = 1'b0;
    step         = 1'b0;
    last         = 1'b0;
    case (state)
      S_IDLE: begin
        if (alu_start_in) begin
          load       = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        alu_busy_out = 1'b1;
        step         = 1'b1;
        last         = (count == CW'(NLIMB - 1));
        if (last) state_next = S_DONE;
      end
      S_DONE: begin
        alu_done_out = 1'b1;
        state_next   = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Slice adder; V uses the sign rule, equivalent to carry-in xor carry-out of the MSB
  // and only meaningful on the top slice.
  always_comb begin
    idx       = int'(count) * LIMB;
    a_sl      = a_q[idx +: LIMB];
    b_sl      = b_q[idx +: LIMB];
    sum       = {1'b0, a_sl} + {1'b0, b_sl} + {{LIMB{1'b0}}, carry_q};
    work_next = work_q;
    work_next[idx +: LIMB] = sum[LIMB-1:0];
    v_slice   = (a_sl[LIMB-1] == b_sl[LIMB-1]) && (sum[LIMB-1] != a_sl[LIMB-1]);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      a_q       <= '0;
      b_q       <= '0;
      work_q    <= '0;
      carry_q   <= 1'b0;
      count     <= '0;
      alu_out   <= '0;
      alu_Z_out <= 1'b0;
      alu_N_out <= 1'b0;
      alu_C_out <= 1'b0;
      alu_V_out <= 1'b0;
    end else begin
      if (load) begin
        a_q     <= alu_A_in;
        b_q     <= alu_op_in[0] ? ~alu_B_in : alu_B_in;
        carry_q <= alu_op_in[1] ? alu_carry_in : alu_op_in[0];
        count   <= '0;
      end
      if (step) begin
        work_q  <= work_next;
        carry_q <= sum[LIMB];
        count   <= count + CW'(1);
      end
      if (last) begin
        alu_out   <= work_next;
        alu_Z_out <= (work_next == '0);
        alu_N_out <= work_next[WIDTH-1];
        alu_C_out <= sum[LIMB];
        alu_V_out <= v_slice;
      end
    end
  end

endmodule

// File: tb/tb_alu_limb_seq.sv
// Directed bench for alu_limb_seq: a 32/8 instance for the main cases and a 16/16
// instance for the single-slice case.
module tb_alu_limb_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // Instance 0: WIDTH=32, LIMB=8
  logic        s0_start = 1'b0, s0_cin = 1'b0;
  logic [1:0]  s0_op = '0;
  logic [31:0] s0_a = '0, s0_b = '0;
  logic        busy0, done0, z0, n0, c0, v0;
  logic [31:0] out0;
  logic [1:0]  st0;

  // Instance 1: WIDTH=16, LIMB=16
  logic        s1_start = 1'b0, s1_cin = 1'b0;
  logic [1:0]  s1_op = '0;
  logic [15:0] s1_a = '0, s1_b = '0;
  logic        busy1, done1, z1, n1, c1, v1;
  logic [15:0] out1;
  logic [1:0]  st1;

  alu_limb_seq #(.WIDTH(32), .LIMB(8)) dut0 (
    .clk_in(clk), .rst_n_in(rst_n), .alu_start_in(s0_start), .alu_op_in(s0_op),
    .alu_carry_in(s0_cin), .alu_A_in(s0_a), .alu_B_in(s0_b), .alu_busy_out(busy0),
    .alu_done_out(done0), .alu_out(out0), .alu_Z_out(z0), .alu_N_out(n0),
    .alu_C_out(c0), .alu_V_out(v0), .dbg_state(st0)
  );

  alu_limb_seq #(.WIDTH(16), .LIMB(16)) dut1 (
    .clk_in(clk), .rst_n_in(rst_n), .alu_start_in(s1_start), .alu_op_in(s1_op),
    .alu_carry_in(s1_cin), .alu_A_in(s1_a), .alu_B_in(s1_b), .alu_busy_out(busy1),
    .alu_done_out(done1), .alu_out(out1), .alu_Z_out(z1), .alu_N_out(n1),
    .alu_C_out(c1), .alu_V_out(v1), .dbg_state(st1)
  );

  logic        cur_sel = 1'b0;
  logic        m_busy, m_done;
  logic [31:0] m_res;
  logic [3:0]  m_flags;

  assign m_busy  = cur_sel ? busy1 : busy0;
  assign m_done  = cur_sel ? done1 : done0;
  assign m_res   = cur_sel ? {16'h0, out1} : out0;
  assign m_flags = cur_sel ? {z1, n1, c1, v1} : {z0, n0, c0, v0};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic sel, input logic start, input logic [1:0] op,
                       input logic cin, input logic [31:0] a, input logic [31:0] b);
    if (sel) begin
      s1_start = start; s1_op = op; s1_cin = cin; s1_a = a[15:0]; s1_b = b[15:0];
    end else begin
      s0_start = start; s0_op = op; s0_cin = cin; s0_a = a; s0_b = b;
    end
  endtask

  // Drive garbage on the operand inputs while the op runs to show they are latched.
  task automatic drive_idle(input logic sel);
    logic [1:0] rop;
    rop = 2'($urandom_range(0, 3));
    drive(sel, 1'b0, rop, 1'($urandom_range(0, 1)), $urandom, $urandom);
  endtask

  task automatic run_op(input string tag, input logic sel, input logic [1:0] op,
                        input logic cin, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input logic [31:0] exp_res,
                        input logic [3:0] exp_flags);
    int lat = 0;
    int bc = 0;
    logic seen = 1'b0;
    @(negedge clk);
    cur_sel = sel;
    drive(sel, 1'b1, op, cin, a, b);
    @(negedge clk);
    drive_idle(sel);
    for (int i = 0; i < 20; i++) begin
      if (m_done) begin
        seen = 1'b1;
        break;
      end
      if (m_busy) bc++;
      @(negedge clk);
      lat++;
    end
    check({tag, ".done_seen"}, 64'(seen), 64'(1));
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".busy_cycles"}, 64'(bc), 64'(exp_lat));
    check({tag, ".busy_at_done"}, 64'(m_busy), 64'(0));
    check({tag, ".result"}, 64'(m_res), 64'(exp_res));
    check({tag, ".flags_zncv"}, 64'(m_flags), 64'(exp_flags));
    @(negedge clk);
    check({tag, ".done_one_cycle"}, 64'(m_done), 64'(0));
    check({tag, ".result_held"}, 64'(m_res), 64'(exp_res));
  endtask

  initial begin
    int dones;
    logic [31:0] res_at_done;

    repeat (3) @(negedge clk);
    check("reset.out0", 64'(out0), 64'(0));
    check("reset.flags0", 64'({z0, n0, c0, v0}), 64'(0));
    check("reset.busy_done0", 64'({busy0, done0}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("idle.busy0", 64'(busy0), 64'(0));

    // Flags packed as {Z,N,C,V}.
    run_op("add_ff_1",   1'b0, 2'b00, 1'b0, 32'h0000_00FF, 32'h0000_0001, 4, 32'h0000_0100, 4'b0000);
    run_op("sub_5_5",    1'b0, 2'b01, 1'b0, 32'h0000_0005, 32'h0000_0005, 4, 32'h0000_0000, 4'b1010);
    run_op("sub_0_1",    1'b0, 2'b01, 1'b1, 32'h0000_0000, 32'h0000_0001, 4, 32'hFFFF_FFFF, 4'b0100);
    run_op("add_ovf",    1'b0, 2'b00, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 4, 32'h8000_0000, 4'b0101);
    run_op("adc_c1",     1'b0, 2'b10, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 4, 32'h0000_0000, 4'b1010);
    run_op("sbc_c0",     1'b0, 2'b11, 1'b0, 32'h0000_0005, 32'h0000_0002, 4, 32'h0000_0002, 4'b0010);

    // Start pulsed again during RUN must be ignored; old result held until done.
    @(negedge clk);
    cur_sel = 1'b0;
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0010, 32'h0000_0020);
    @(negedge clk);
    drive_idle(1'b0);
    check("rerun.held_k", 64'(out0), 64'(32'h2));
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0001, 32'h0000_0001);
    check("rerun.held_k1", 64'(out0), 64'(32'h2));
    @(negedge clk);
    drive_idle(1'b0);
    dones = 0;
    res_at_done = '0;
    for (int i = 0; i < 12; i++) begin
      if (done0) begin
        dones++;
        res_at_done = out0;
      end else if (busy0) begin
        check("rerun.held_busy", 64'(out0), 64'(32'h2));
      end
      @(negedge clk);
    end
    check("rerun.done_count", 64'(dones), 64'(1));
    check("rerun.result", 64'(res_at_done), 64'(32'h30));

    // Reset after two slices: everything clears at once and no done follows.
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h8F0F_0F0F, 32'h8101_0101);
    @(negedge clk);
    drive_idle(1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.out", 64'(out0), 64'(0));
    check("abort.flags", 64'({z0, n0, c0, v0}), 64'(0));
    check("abort.busy_done", 64'({busy0, done0}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (done0) dones++;
      @(negedge clk);
    end
    check("abort.no_done", 64'(dones), 64'(0));
    check("abort.out_still0", 64'(out0), 64'(0));
    run_op("after_abort", 1'b0, 2'b00, 1'b0, 32'h1234_5678, 32'h1111_1111, 4, 32'h2345_6789, 4'b0000);

    // Single-slice instance.
    run_op("w16_add",    1'b1, 2'b00, 1'b0, 32'h0000_00FF, 32'h0000_0001, 1, 32'h0000_0100, 4'b0000);
    run_op("w16_sub_ovf", 1'b1, 2'b01, 1'b0, 32'h0000_8000, 32'h0000_0001, 1, 32'h0000_7FFF, 4'b0011);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
